// File: rtl/loader_pkg.sv
// Shared definitions for the UART boot loader: frame header,
// field widths and the state encodings of both FSMs.
package loader_pkg;

    localparam logic [7:0] LDR_HDR = 8'hA5;
    localparam int BYTE_W = 8;
    localparam int LEN_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ldr_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_OK,
        RX_BAD
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-FF synchroniser, mid-bit sampling timer,
// one-cycle rx_valid / rx_ferr pulses after the stop-bit sample.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_ferr
);

    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] FULL = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] HALF = TW'(CLK_DIV / 2 - 1);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic              rx_s1;
    logic              rx_s2;
    logic              rx_s3;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] shreg;
    logic              tick;
    logic              fall;

    assign tick = (timer == '0);
    assign fall = rx_s3 & ~rx_s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sync flops reset low so a line held low across reset is not
    // mistaken for a start bit; only a genuine high-to-low edge counts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1   <= 1'b0;
            rx_s2   <= 1'b0;
            rx_s3   <= 1'b0;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (state == RX_IDLE) begin
                timer   <= HALF;
                bit_cnt <= '0;
            end else if (tick) begin
                timer <= FULL;
            end else begin
                timer <= timer - 1'b1;
            end
            if (state == RX_DATA && tick) begin
                shreg   <= {rx_s2, shreg[BYTE_W-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RX_IDLE: begin
                if (fall) state_nxt = RX_START;
            end
            RX_START: begin
                if (tick) state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (tick && bit_cnt == 3'd7) state_nxt = RX_STOP;
            end
            RX_STOP: begin
                if (tick) state_nxt = rx_s2 ? RX_OK : RX_BAD;
            end
            RX_OK:   state_nxt = RX_IDLE;
            RX_BAD:  state_nxt = RX_IDLE;
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_data  = shreg;
        rx_valid = (state == RX_OK);
        rx_ferr  = (state == RX_BAD);
    end

endmodule

// File: rtl/iram_uart_loader.sv
// Boot loader: parses A5|LEN|words|CSUM frames from the UART and
// writes the image into IRAM, releasing the CPU on a good checksum.
module iram_uart_loader
    import loader_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              iram_we,
    output logic [ADDR_W-1:0] iram_waddr,
    output logic [WORD_W-1:0] iram_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              load_err
);

    localparam logic [LEN_W:0] DEPTH = (LEN_W + 1)'(1) << ADDR_W;

    ldr_state_t        state;
    ldr_state_t        state_nxt;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ferr;
    logic [BYTE_W-1:0] len_lo;
    logic [LEN_W-1:0]  len_full;
    logic [ADDR_W-1:0] len_m1;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_idx;
    logic [23:0]       wbuf;
    logic [BYTE_W-1:0] csum;
    logic              err_q;
    logic              last_word;

    uart_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rx       (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    assign len_full  = {rx_data, len_lo};
    assign last_word = (addr == len_m1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (rx_ferr && state != ST_DONE) begin
            state_nxt = ST_ERR;
        end else if (rx_valid) begin
            unique case (state)
                ST_IDLE, ST_ERR: begin
                    if (rx_data == LDR_HDR) state_nxt = ST_LEN0;
                end
                ST_LEN0: state_nxt = ST_LEN1;
                ST_LEN1: begin
                    if (len_full == '0) state_nxt = ST_CSUM;
                    else if ({1'b0, len_full} > DEPTH) state_nxt = ST_ERR;
                    else state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    if (byte_idx == 2'd3 && last_word) state_nxt = ST_CSUM;
                end
                ST_CSUM: state_nxt = (rx_data == csum) ? ST_DONE : ST_ERR;
                default: state_nxt = state;
            endcase
        end
    end

    // addr stops on the last word so LEN == DEPTH never wraps it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_lo     <= '0;
            len_m1     <= '0;
            addr       <= '0;
            byte_idx   <= '0;
            wbuf       <= '0;
            csum       <= '0;
            err_q      <= 1'b0;
            iram_we    <= 1'b0;
            iram_waddr <= '0;
            iram_wdata <= '0;
        end else begin
            iram_we <= 1'b0;
            if (rx_valid) begin
                unique case (state)
                    ST_IDLE, ST_ERR: begin
                        if (rx_data == LDR_HDR) begin
                            csum     <= '0;
                            addr     <= '0;
                            byte_idx <= '0;
                        end
                    end
                    ST_LEN0: len_lo <= rx_data;
                    ST_LEN1: begin
                        len_m1   <= ADDR_W'(len_full - 1'b1);
                        addr     <= '0;
                        byte_idx <= '0;
                    end
                    ST_DATA: begin
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 1'b1;
                        wbuf     <= {rx_data, wbuf[23:8]};
                        if (byte_idx == 2'd3) begin
                            iram_we    <= 1'b1;
                            iram_waddr <= addr;
                            iram_wdata <= {rx_data, wbuf};
                            if (!last_word) addr <= addr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (state_nxt == ST_ERR) err_q <= 1'b1;
        end
    end

    always_comb begin
        cpu_run  = (state == ST_DONE);
        busy     = (state == ST_LEN0) || (state == ST_LEN1) ||
                   (state == ST_DATA) || (state == ST_CSUM);
        load_err = err_q;
    end

endmodule

// File: tb/tb_iram_uart_loader.sv
// Directed testbench for iram_uart_loader (CLK_DIV=16, ADDR_W=4).
module tb_iram_uart_loader;

    localparam int CLK_DIV = 16;
    localparam int ADDR_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              uart_rx = 1'b1;
    logic              iram_we;
    logic [ADDR_W-1:0] iram_waddr;
    logic [31:0]       iram_wdata;
    logic              cpu_run;
    logic              busy;
    logic              load_err;

    int nvec = 0;
    int nfail = 0;

    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    int                we_long = 0;
    int                rxv_cnt = 0;
    logic              we_prev = 1'b0;
    logic [7:0]        frm[$];

    iram_uart_loader #(
        .CLK_DIV (CLK_DIV),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .iram_we    (iram_we),
        .iram_waddr (iram_waddr),
        .iram_wdata (iram_wdata),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (iram_we) begin
            wa_q.push_back(iram_waddr);
            wd_q.push_back(iram_wdata);
            if (we_prev) we_long++;
        end
        we_prev = iram_we;
        if (dut.rx_valid) rxv_cnt++;
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        we_long = 0;
        rxv_cnt = 0;
    endtask

    task automatic bit_wait();
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        bit_wait();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            bit_wait();
        end
        uart_rx = stop;
        bit_wait();
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frm();
        foreach (frm[i]) send_byte(frm[i], 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_log();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        nvec++; if (iram_we !== 1'b0) begin nfail++; $display("FAIL rst_we got %b want 0", iram_we); end
        nvec++; if (iram_waddr !== '0) begin nfail++; $display("FAIL rst_waddr got %h want 0", iram_waddr); end
        nvec++; if (iram_wdata !== '0) begin nfail++; $display("FAIL rst_wdata got %h want 0", iram_wdata); end
        nvec++; if ({cpu_run, busy, load_err} !== 3'b000) begin nfail++; $display("FAIL rst_flags got %b want 000", {cpu_run, busy, load_err}); end
        reset = 1'b1;
        @(negedge clk);
        clear_log();
    endtask

    task automatic test_basic();
        logic [31:0] d0, d1;
        pulse_reset();
        send_byte(8'hA5, 1'b1);
        nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL basic_busy got %b want 1", busy); end
        frm = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        send_frm();
        repeat (4) @(negedge clk);
        d0 = (wd_q.size() > 0) ? wd_q[0] : 32'hx;
        d1 = (wd_q.size() > 1) ? wd_q[1] : 32'hx;
        nvec++; if (wd_q.size() != 2) begin nfail++; $display("FAIL basic_nwr got %0d want 2", wd_q.size()); end
        nvec++; if (d0 !== 32'h12345678) begin nfail++; $display("FAIL basic_w0 got %h want 12345678", d0); end
        nvec++; if (d1 !== 32'hDEADBEEF) begin nfail++; $display("FAIL basic_w1 got %h want deadbeef", d1); end
        nvec++; if (wa_q.size() == 2 && (wa_q[0] !== 4'd0 || wa_q[1] !== 4'd1)) begin nfail++; $display("FAIL basic_addr got %h,%h want 0,1", wa_q[0], wa_q[1]); end
        nvec++; if (we_long != 0) begin nfail++; $display("FAIL basic_we_width got %0d long pulses want 0", we_long); end
        nvec++; if ({cpu_run, busy, load_err} !== 3'b100) begin nfail++; $display("FAIL basic_flags got %b want 100", {cpu_run, busy, load_err}); end
    endtask

    task automatic test_bad_csum();
        logic [31:0] d1;
        pulse_reset();
        frm = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
        send_frm();
        repeat (4) @(negedge clk);
        d1 = (wd_q.size() > 1) ? wd_q[1] : 32'hx;
        nvec++; if (wd_q.size() != 2) begin nfail++; $display("FAIL badcs_nwr got %0d want 2", wd_q.size()); end
        nvec++; if (d1 !== 32'hDEADBEEF) begin nfail++; $display("FAIL badcs_w1 got %h want deadbeef", d1); end
        nvec++; if ({cpu_run, busy, load_err} !== 3'b001) begin nfail++; $display("FAIL badcs_flags got %b want 001", {cpu_run, busy, load_err}); end
        frm[11] = 8'h2A;
        send_frm();
        repeat (4) @(negedge clk);
        nvec++; if (wd_q.size() != 4) begin nfail++; $display("FAIL retry_nwr got %0d want 4", wd_q.size()); end
        nvec++; if ({cpu_run, busy, load_err} !== 3'b101) begin nfail++; $display("FAIL retry_flags got %b want 101", {cpu_run, busy, load_err}); end
    endtask

    task automatic test_zero_len();
        pulse_reset();
        frm = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_frm();
        repeat (4) @(negedge clk);
        nvec++; if (wd_q.size() != 0) begin nfail++; $display("FAIL zlen_nwr got %0d want 0", wd_q.size()); end
        nvec++; if ({cpu_run, busy, load_err} !== 3'b100) begin nfail++; $display("FAIL zlen_flags got %b want 100", {cpu_run, busy, load_err}); end
        frm = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_frm();
        repeat (4) @(negedge clk);
        nvec++; if (wd_q.size() != 0) begin nfail++; $display("FAIL done_ignore_nwr got %0d want 0", wd_q.size()); end
        nvec++; if ({cpu_run, busy, load_err} !== 3'b100) begin nfail++; $display("FAIL done_ignore_flags got %b want 100", {cpu_run, busy, load_err}); end
    endtask

    task automatic test_len_bounds();
        logic [7:0]  cs;
        logic [31:0] w;
        logic [31:0] last_w;
        logic [31:0] got_w;
        int          bad_addr;
        pulse_reset();
        frm = '{8'hA5, 8'h11, 8'h00};
        send_frm();
        repeat (4) @(negedge clk);
        nvec++; if (wd_q.size() != 0) begin nfail++; $display("FAIL len17_nwr got %0d want 0", wd_q.size()); end
        nvec++; if ({cpu_run, busy, load_err} !== 3'b001) begin nfail++; $display("FAIL len17_flags got %b want 001", {cpu_run, busy, load_err}); end
        pulse_reset();
        frm = '{8'hA5, 8'h10, 8'h00};
        cs = 8'h00;
        last_w = 32'h0;
        for (int i = 0; i < 16; i++) begin
            w = {8'(i), 8'hC3, 8'(i * 5), 8'h3C ^ 8'(i)};
            for (int k = 0; k < 4; k++) begin
                frm.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
            last_w = w;
        end
        frm.push_back(cs);
        send_frm();
        repeat (4) @(negedge clk);
        bad_addr = 0;
        foreach (wa_q[i]) if (wa_q[i] !== 4'(i)) bad_addr++;
        got_w = (wd_q.size() == 16) ? wd_q[15] : 32'hx;
        nvec++; if (wd_q.size() != 16) begin nfail++; $display("FAIL len16_nwr got %0d want 16", wd_q.size()); end
        nvec++; if (bad_addr != 0) begin nfail++; $display("FAIL len16_addr got %0d wrong addrs want 0", bad_addr); end
        nvec++; if (got_w !== last_w) begin nfail++; $display("FAIL len16_last got %h want %h", got_w, last_w); end
        nvec++; if ({cpu_run, busy, load_err} !== 3'b100) begin nfail++; $display("FAIL len16_flags got %b want 100", {cpu_run, busy, load_err}); end
    endtask

    task automatic test_rx_faults();
        pulse_reset();
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        nvec++; if (rxv_cnt != 0) begin nfail++; $display("FAIL false_start got %0d rx_valid want 0", rxv_cnt); end
        nvec++; if ({busy, load_err} !== 2'b00) begin nfail++; $display("FAIL false_start_flags got %b want 00", {busy, load_err}); end
        frm = '{8'hA5, 8'h01, 8'h00, 8'h78};
        send_frm();
        nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL ferr_pre_busy got %b want 1", busy); end
        send_byte(8'h56, 1'b0);
        repeat (4) @(negedge clk);
        nvec++; if ({cpu_run, busy, load_err} !== 3'b001) begin nfail++; $display("FAIL ferr_flags got %b want 001", {cpu_run, busy, load_err}); end
        nvec++; if (wd_q.size() != 0) begin nfail++; $display("FAIL ferr_nwr got %0d want 0", wd_q.size()); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d0, d1;
        pulse_reset();
        frm = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE};
        send_frm();
        nvec++; if (wd_q.size() != 1) begin nfail++; $display("FAIL abort_pre_nwr got %0d want 1", wd_q.size()); end
        uart_rx = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nvec++; if (iram_waddr !== '0 || iram_wdata !== '0 || iram_we !== 1'b0) begin nfail++; $display("FAIL abort_wport got %b/%h/%h want 0/0/0", iram_we, iram_waddr, iram_wdata); end
        nvec++; if ({cpu_run, busy, load_err} !== 3'b000) begin nfail++; $display("FAIL abort_flags got %b want 000", {cpu_run, busy, load_err}); end
        reset = 1'b1;
        repeat (40) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        clear_log();
        frm = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        send_frm();
        repeat (4) @(negedge clk);
        d0 = (wd_q.size() > 0) ? wd_q[0] : 32'hx;
        d1 = (wd_q.size() > 1) ? wd_q[1] : 32'hx;
        nvec++; if (wd_q.size() != 2) begin nfail++; $display("FAIL reload_nwr got %0d want 2", wd_q.size()); end
        nvec++; if (d0 !== 32'h12345678 || d1 !== 32'hDEADBEEF) begin nfail++; $display("FAIL reload_data got %h,%h want 12345678,deadbeef", d0, d1); end
        nvec++; if ({cpu_run, busy, load_err} !== 3'b100) begin nfail++; $display("FAIL reload_flags got %b want 100", {cpu_run, busy, load_err}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_zero_len();
        test_len_bounds();
        test_rx_faults();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
